mutative_mem_arbiter: RTL

MUTATIVE_MEM_ARBITER -- requirements
Module: mutative_mem_arbiter

---
 rtl/mutative_mem_arbiter.sv | 80 ++++++++
 1 files changed

// File: rtl/mutative_mem_arbiter.sv
// mutative_mem_arbiter: two-port (icache p0 / dcache p1) arbiter onto one line-wide memory port.
// Define MUTATIVE_ARB_RR_EN for round-robin tie-breaking; default is fixed priority to p1.
module mutative_mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic                  p0_read,
   input  logic                  p0_write,
   input  logic [LINE_WIDTH-1:0] p0_wdata,
   output logic [LINE_WIDTH-1:0] p0_rdata,
   output logic                  p0_resp,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic                  p1_read,
   input  logic                  p1_write,
   input  logic [LINE_WIDTH-1:0] p1_wdata,
   output logic [LINE_WIDTH-1:0] p1_rdata,
   output logic                  p1_resp,
   output logic [ADDR_WIDTH-1:0] dfp_addr,
   output logic                  dfp_read,
   output logic                  dfp_write,
   output logic [LINE_WIDTH-1:0] dfp_wdata,
   input  logic [LINE_WIDTH-1:0] dfp_rdata,
   input  logic                  dfp_resp
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t                state;
   logic                  grant, last_grant, write_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LINE_WIDTH-1:0] wdata_q;
   logic                  req0, req1, gnt, busy, fin;
   assign req0 = p0_read | p0_write;
   assign req1 = p1_read | p1_write;
`ifdef MUTATIVE_ARB_RR_EN
   assign gnt = (req0 & req1) ? ~last_grant : req1;
`else
   // fixed priority to p1; last_grant is tracked but never changes the outcome
   assign gnt = (req0 & req1) ? (last_grant | 1'b1) : req1;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         write_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         case (state)
            IDLE: if (req0 | req1) begin
               state      <= BUSY;
               grant      <= gnt;
               last_grant <= gnt;
               write_q    <= gnt ? p1_write : p0_write;
               addr_q     <= gnt ? p1_addr : p0_addr;
               wdata_q    <= gnt ? p1_wdata : p0_wdata;
            end
            BUSY: if (dfp_resp) state <= DONE;
            DONE: begin
               state <= IDLE;
               grant <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
   // rst gating drops a response that lands in the reset cycle
   assign busy      = (state == BUSY) & ~rst;
   assign fin       = busy & dfp_resp;
   assign dfp_read  = busy & ~write_q;
   assign dfp_write = busy & write_q;
   assign dfp_addr  = busy ? addr_q : '0;
   assign dfp_wdata = busy ? wdata_q : '0;
   assign p0_resp   = fin & ~grant;
   assign p1_resp   = fin & grant;
   assign p0_rdata  = p0_resp ? dfp_rdata : '0;
   assign p1_rdata  = p1_resp ? dfp_rdata : '0;
endmodule
